// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel/line counters with registered
// address, active-video, sync, line/frame strobes and a wrapping frame counter.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_PW     = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_PW     = 2,
    parameter int   V_BP     = 29,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   ADR_W    = 10,
    parameter int   FRM_W    = 8
) (
    input  logic             ckVideo,
    input  logic             rstVideo_n,
    input  logic             ceVideo,
    input  logic             run,
    output logic [ADR_W-1:0] adrHor,
    output logic [ADR_W-1:0] adrVer,
    output logic             flgActiveVideo,
    output logic             HS,
    output logic             VS,
    output logic             stbLine,
    output logic             stbFrame,
    output logic [FRM_W-1:0] cntFrame
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_PW + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_PW + V_BP;

    // Every boundary is below the total, which fits in ADR_W bits.
    localparam logic [ADR_W-1:0] H_LAST   = ADR_W'(H_TOTAL - 1);
    localparam logic [ADR_W-1:0] V_LAST   = ADR_W'(V_TOTAL - 1);
    localparam logic [ADR_W-1:0] H_ACT    = ADR_W'(H_ACTIVE);
    localparam logic [ADR_W-1:0] V_ACT    = ADR_W'(V_ACTIVE);
    localparam logic [ADR_W-1:0] HS_BEG   = ADR_W'(H_ACTIVE + H_FP);
    localparam logic [ADR_W-1:0] HS_END   = ADR_W'(H_ACTIVE + H_FP + H_PW - 1);
    localparam logic [ADR_W-1:0] VS_BEG   = ADR_W'(V_ACTIVE + V_FP);
    localparam logic [ADR_W-1:0] VS_END   = ADR_W'(V_ACTIVE + V_FP + V_PW - 1);

    logic [ADR_W-1:0] cntHor;
    logic [ADR_W-1:0] cntVer;
    logic             wrapHor;
    logic             wrapVer;
    logic             isActive;
    logic             hsOn;
    logic             vsOn;
    logic             atLineStart;
    logic             atFrameStart;

    always_comb begin
        wrapHor      = (cntHor == H_LAST);
        wrapVer      = (cntVer == V_LAST);
        isActive     = (cntHor < H_ACT) && (cntVer < V_ACT);
        hsOn         = (cntHor >= HS_BEG) && (cntHor <= HS_END);
        vsOn         = (cntVer >= VS_BEG) && (cntVer <= VS_END);
        atLineStart  = (cntHor == '0);
        atFrameStart = atLineStart && (cntVer == '0);
    end

    always_ff @(posedge ckVideo or negedge rstVideo_n) begin
        if (!rstVideo_n) begin
            cntHor         <= '0;
            cntVer         <= '0;
            adrHor         <= '0;
            adrVer         <= '0;
            flgActiveVideo <= 1'b0;
            HS             <= ~HS_POL;
            VS             <= ~VS_POL;
            stbLine        <= 1'b0;
            stbFrame       <= 1'b0;
            cntFrame       <= '0;
        end else if (!run) begin
            // Parked: blank everything regardless of the pixel enable, keep the frame count.
            cntHor         <= '0;
            cntVer         <= '0;
            adrHor         <= '0;
            adrVer         <= '0;
            flgActiveVideo <= 1'b0;
            HS             <= ~HS_POL;
            VS             <= ~VS_POL;
            stbLine        <= 1'b0;
            stbFrame       <= 1'b0;
        end else begin
            stbLine  <= ceVideo && atLineStart;
            stbFrame <= ceVideo && atFrameStart;
            if (ceVideo) begin
                adrHor         <= cntHor;
                adrVer         <= cntVer;
                flgActiveVideo <= isActive;
                HS             <= hsOn ? HS_POL : ~HS_POL;
                VS             <= vsOn ? VS_POL : ~VS_POL;
                if (wrapHor) begin
                    cntHor <= '0;
                    if (wrapVer) begin
                        cntVer   <= '0;
                        cntFrame <= cntFrame + FRM_W'(1);
                    end else begin
                        cntVer <= cntVer + ADR_W'(1);
                    end
                end else begin
                    cntHor <= cntHor + ADR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing, a short-line/full-frame
// variant for vertical timing, and a tiny active-high configuration.
module tb_vga_timing_gen;

    logic ckVideo = 1'b0;
    always #5 ckVideo = ~ckVideo;

    logic rstVideo_n;
    logic ceA, runA, ceB, runB, ceC, runC;

    logic [9:0] aHor, aVer, bHor, bVer, cHor, cVer;
    logic       aAct, aHs, aVs, aStbL, aStbF;
    logic       bAct, bHs, bVs, bStbL, bStbF;
    logic       cAct, cHs, cVs, cStbL, cStbF;
    logic [7:0] aFrm, bFrm, cFrm;

    int checks = 0;
    int errors = 0;

    // Default 800x521 timing.
    vga_timing_gen dutA (
        .ckVideo(ckVideo), .rstVideo_n(rstVideo_n), .ceVideo(ceA), .run(runA),
        .adrHor(aHor), .adrVer(aVer), .flgActiveVideo(aAct), .HS(aHs), .VS(aVs),
        .stbLine(aStbL), .stbFrame(aStbF), .cntFrame(aFrm)
    );

    // 12-pixel lines with the default vertical timing, so a whole frame is 6252 clocks.
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_PW(2), .H_BP(1)
    ) dutB (
        .ckVideo(ckVideo), .rstVideo_n(rstVideo_n), .ceVideo(ceB), .run(runB),
        .adrHor(bHor), .adrVer(bVer), .flgActiveVideo(bAct), .HS(bHs), .VS(bVs),
        .stbLine(bStbL), .stbFrame(bStbF), .cntFrame(bFrm)
    );

    // Small configuration with active-high syncs: 8-clock lines, 48-clock frames.
    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_PW(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_PW(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dutC (
        .ckVideo(ckVideo), .rstVideo_n(rstVideo_n), .ceVideo(ceC), .run(runC),
        .adrHor(cHor), .adrVer(cVer), .flgActiveVideo(cAct), .HS(cHs), .VS(cVs),
        .stbLine(cStbL), .stbFrame(cStbF), .cntFrame(cFrm)
    );

    task automatic tick;
        @(posedge ckVideo);
        #1;
    endtask

    task automatic test_reset;
        tick;
        tick;
        checks++; if (aHor !== 10'd0) begin errors++; $display("FAIL reset_adrHor: got %0d want 0", aHor); end
        checks++; if (aVer !== 10'd0) begin errors++; $display("FAIL reset_adrVer: got %0d want 0", aVer); end
        checks++; if (aAct !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", aAct); end
        checks++; if (aHs !== 1'b1 || aVs !== 1'b1) begin errors++; $display("FAIL reset_syncA: got HS=%b VS=%b want 1 1", aHs, aVs); end
        checks++; if (cHs !== 1'b0 || cVs !== 1'b0) begin errors++; $display("FAIL reset_syncC: got HS=%b VS=%b want 0 0", cHs, cVs); end
        checks++; if (aStbL !== 1'b0 || aStbF !== 1'b0) begin errors++; $display("FAIL reset_strobes: got %b%b want 00", aStbL, aStbF); end
        checks++; if (aFrm !== 8'd0) begin errors++; $display("FAIL reset_cntFrame: got %0d want 0", aFrm); end

        runA = 1'b1;
        ceA  = 1'b1;
        rstVideo_n = 1'b1;
        tick;
        checks++; if (aHor !== 10'd0 || aVer !== 10'd0) begin errors++; $display("FAIL first_pos: got (%0d,%0d) want (0,0)", aHor, aVer); end
        checks++; if (aAct !== 1'b1) begin errors++; $display("FAIL first_active: got %b want 1", aAct); end
        checks++; if (aStbL !== 1'b1 || aStbF !== 1'b1) begin errors++; $display("FAIL first_strobes: got %b%b want 11", aStbL, aStbF); end

        repeat (49) tick;
        checks++; if (aHor !== 10'd49 || aStbL !== 1'b0) begin errors++; $display("FAIL midline_pos: got h=%0d stb=%b want 49 0", aHor, aStbL); end

        // Asynchronous reset in the middle of line 0.
        rstVideo_n = 1'b0;
        #1;
        checks++; if (aHor !== 10'd0 || aVer !== 10'd0) begin errors++; $display("FAIL async_reset_pos: got (%0d,%0d) want (0,0)", aHor, aVer); end
        checks++; if (aAct !== 1'b0 || aHs !== 1'b1 || aVs !== 1'b1) begin errors++; $display("FAIL async_reset_flags: got act=%b HS=%b VS=%b want 0 1 1", aAct, aHs, aVs); end
        checks++; if (aFrm !== 8'd0 || aStbL !== 1'b0) begin errors++; $display("FAIL async_reset_misc: got frm=%0d stb=%b want 0 0", aFrm, aStbL); end
        #1;
        rstVideo_n = 1'b1;
        tick;
        checks++; if (aHor !== 10'd0 || aVer !== 10'd0 || aStbF !== 1'b1) begin errors++; $display("FAIL release_frame: got (%0d,%0d) stbF=%b want (0,0) 1", aHor, aVer, aStbF); end
    endtask

    // Starts with dutA showing (0,0); walks two full lines.
    task automatic test_hor_timing;
        int expH, expV, hsLow, prevH, prevV;
        bit expHs, expAct;
        hsLow = 0;
        prevH = 0;
        prevV = 0;
        for (int i = 1; i <= 1600; i++) begin
            tick;
            expH   = i % 800;
            expV   = i / 800;
            expHs  = !(expH >= 656 && expH <= 751);
            expAct = (expH < 640) && (expV < 480);
            if (i < 800 && aHs === 1'b0) hsLow++;
            checks++; if (aHor !== 10'(expH) || aVer !== 10'(expV)) begin errors++; $display("FAIL hor_pos: got (%0d,%0d) want (%0d,%0d)", aHor, aVer, expH, expV); end
            checks++; if (aHs !== expHs) begin errors++; $display("FAIL hor_hs at h=%0d: got %b want %b", expH, aHs, expHs); end
            checks++; if (aAct !== expAct) begin errors++; $display("FAIL hor_active at h=%0d: got %b want %b", expH, aAct, expAct); end
            checks++; if (aStbL !== (expH == 0)) begin errors++; $display("FAIL hor_stbLine at h=%0d: got %b", expH, aStbL); end
            if (prevH == 799) begin
                checks++; if (aHor !== 10'd0 || aVer !== 10'(prevV + 1)) begin errors++; $display("FAIL line_wrap: got (%0d,%0d) want (0,%0d)", aHor, aVer, prevV + 1); end
            end
            prevH = int'(aHor);
            prevV = int'(aVer);
        end
        checks++; if (hsLow != 96) begin errors++; $display("FAIL hs_width: got %0d want 96", hsLow); end
    endtask

    task automatic test_ce_pacing;
        int firstStb, secondStb;
        bit expStb;
        firstStb  = -1;
        secondStb = -1;
        runA = 1'b0;
        tick;
        checks++; if (aHor !== 10'd0 || aVer !== 10'd0) begin errors++; $display("FAIL park_pos: got (%0d,%0d) want (0,0)", aHor, aVer); end
        runA = 1'b1;
        for (int k = 0; k <= 2403; k++) begin
            ceA = (k % 3 == 0);
            tick;
            expStb = (k % 3 == 0) && ((k / 3) % 800 == 0);
            if (aStbL === 1'b1) begin
                if (firstStb < 0) firstStb = k;
                else if (secondStb < 0) secondStb = k;
            end
            checks++; if (aHor !== 10'((k / 3) % 800)) begin errors++; $display("FAIL ce_hold k=%0d: got %0d want %0d", k, aHor, (k / 3) % 800); end
            checks++; if (aStbL !== expStb) begin errors++; $display("FAIL ce_stbLine k=%0d: got %b want %b", k, aStbL, expStb); end
            if (k == 2400) begin
                checks++; if (aVer !== 10'd1) begin errors++; $display("FAIL ce_next_line: got %0d want 1", aVer); end
            end
        end
        checks++; if (secondStb - firstStb != 2400) begin errors++; $display("FAIL ce_line_len: got %0d want 2400", secondStb - firstStb); end
    endtask

    task automatic test_run_drop;
        ceA  = 1'b1;
        runA = 1'b0;
        tick;
        runA = 1'b1;
        tick;
        repeat (1100) tick;
        checks++; if (aHor !== 10'd300 || aVer !== 10'd1 || aAct !== 1'b1) begin errors++; $display("FAIL drop_setup: got (%0d,%0d) act=%b want (300,1) 1", aHor, aVer, aAct); end
        runA = 1'b0;
        tick;
        checks++; if (aHor !== 10'd0 || aVer !== 10'd0) begin errors++; $display("FAIL drop_pos: got (%0d,%0d) want (0,0)", aHor, aVer); end
        checks++; if (aAct !== 1'b0 || aHs !== 1'b1 || aVs !== 1'b1) begin errors++; $display("FAIL drop_flags: got act=%b HS=%b VS=%b want 0 1 1", aAct, aHs, aVs); end
        ceA = 1'b0;
        tick;
        checks++; if (aHor !== 10'd0 || aStbL !== 1'b0 || aStbF !== 1'b0) begin errors++; $display("FAIL drop_noce: got h=%0d stb=%b%b want 0 00", aHor, aStbL, aStbF); end
        runA = 1'b1;
        tick;
        checks++; if (aStbF !== 1'b0) begin errors++; $display("FAIL rerun_noce_stbFrame: got %b want 0", aStbF); end
        ceA = 1'b1;
        tick;
        checks++; if (aStbF !== 1'b1 || aStbL !== 1'b1 || aHor !== 10'd0) begin errors++; $display("FAIL rerun_stbFrame: got stb=%b%b h=%0d want 11 0", aStbL, aStbF, aHor); end
        checks++; if (aFrm !== 8'd0) begin errors++; $display("FAIL rerun_cntFrame: got %0d want 0", aFrm); end
    endtask

    task automatic test_frame_wrap;
        int expH, expV, vsLow;
        bit expVs, expHs;
        vsLow = 0;
        runB  = 1'b1;
        ceB   = 1'b1;
        for (int k = 0; k <= 6263; k++) begin
            tick;
            expH  = k % 12;
            expV  = (k / 12) % 521;
            expVs = !(expV >= 490 && expV <= 491);
            expHs = !(expH >= 9 && expH <= 10);
            if (k < 6252 && bVs === 1'b0) vsLow++;
            checks++; if (bHor !== 10'(expH) || bVer !== 10'(expV)) begin errors++; $display("FAIL frm_pos k=%0d: got (%0d,%0d) want (%0d,%0d)", k, bHor, bVer, expH, expV); end
            checks++; if (bVs !== expVs || bHs !== expHs) begin errors++; $display("FAIL frm_sync k=%0d: got HS=%b VS=%b want %b %b", k, bHs, bVs, expHs, expVs); end
            checks++; if (bStbF !== (expH == 0 && expV == 0)) begin errors++; $display("FAIL frm_stbFrame k=%0d: got %b", k, bStbF); end
            if (k == 6250) begin
                checks++; if (bFrm !== 8'd0) begin errors++; $display("FAIL frm_count_before: got %0d want 0", bFrm); end
            end
            if (k == 6252) begin
                checks++; if (bFrm !== 8'd1) begin errors++; $display("FAIL frm_count_after: got %0d want 1", bFrm); end
            end
        end
        checks++; if (vsLow != 24) begin errors++; $display("FAIL vs_width: got %0d want 24", vsLow); end
    endtask

    task automatic test_small_config;
        int expH, expV;
        bit expHs, expVs, expAct;
        runC = 1'b1;
        ceC  = 1'b1;
        for (int k = 0; k <= 12288; k++) begin
            tick;
            expH   = k % 8;
            expV   = (k / 8) % 6;
            expHs  = (expH >= 5 && expH <= 6);
            expVs  = (expV == 4);
            expAct = (expH < 4) && (expV < 3);
            checks++; if (cHor !== 10'(expH) || cVer !== 10'(expV)) begin errors++; $display("FAIL small_pos k=%0d: got (%0d,%0d) want (%0d,%0d)", k, cHor, cVer, expH, expV); end
            checks++; if (cHs !== expHs || cVs !== expVs) begin errors++; $display("FAIL small_sync k=%0d: got HS=%b VS=%b want %b %b", k, cHs, cVs, expHs, expVs); end
            checks++; if (cAct !== expAct) begin errors++; $display("FAIL small_active k=%0d: got %b want %b", k, cAct, expAct); end
            checks++; if (cStbL !== (expH == 0) || cStbF !== (k % 48 == 0)) begin errors++; $display("FAIL small_strobes k=%0d: got %b%b", k, cStbL, cStbF); end
            if (k % 48 == 0) begin
                checks++; if (cFrm !== 8'((k / 48) % 256)) begin errors++; $display("FAIL small_cntFrame k=%0d: got %0d want %0d", k, cFrm, (k / 48) % 256); end
            end
        end
    endtask

    initial begin
        rstVideo_n = 1'b0;
        ceA = 1'b0; runA = 1'b0;
        ceB = 1'b0; runB = 1'b0;
        ceC = 1'b0; runC = 1'b0;
        test_reset;
        test_hor_timing;
        test_ce_pacing;
        test_run_drop;
        test_frame_wrap;
        test_small_config;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
